mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of busy cycles without MemAck before timeout (only used when MEMARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 IFReq  input  1  instruction-fetch request, held until IFReady.
REQ-005 IFAdr  input  32  fetch address, stable while IFReq is high.
REQ-006 IFReady  output  1  one-cycle pulse, IFInstr valid.
REQ-007 IFInstr  output  32  fetched word.
REQ-008 DReq  input  1  data (load/store) request, held until DReady.
REQ-009 DWrite  input  1  1 = store, 0 = load.
REQ-010 DAdr  input  32  data address.
REQ-011 DWriteData  input  32  store data, already lane-formatted.
REQ-012 DByteEn  input  4  store byte enables.
REQ-013 DReady  output  1  one-cycle pulse, data access complete.
REQ-014 DReadData  output  32  raw load word.
REQ-015 MemReq, MemWrite  output  1 each  shared-port request and write strobe.
REQ-016 MemAdr, MemWriteData  output  32 each  shared-port address and store data.
REQ-017 MemByteEn  output  4  shared-port byte enables.
REQ-018 MemReadData  input  32  port read data, valid with MemAck.
REQ-019 MemAck  input  1  port completion, one cycle.
REQ-020 Busy  output  1  high in any state other than IDLE.
REQ-021 TimeoutErr  output  1  sticky timeout flag.

Function
REQ-022 The FSM SHALL have states IDLE, IF_BUSY, D_BUSY and RESP.
REQ-023 In IDLE with DReq=1, the arbiter SHALL latch DWrite, DAdr, DWriteData and DByteEn and go to D_BUSY; data has fixed priority over fetch.
REQ-024 In IDLE with DReq=0 and IFReq=1, the arbiter SHALL latch IFAdr and go to IF_BUSY.
REQ-025 All Mem* outputs SHALL be registered; MemReq SHALL be 1 exactly in IF_BUSY and D_BUSY, with the address, data and enables held stable from the latch.
REQ-026 In IF_BUSY, MemWrite and MemByteEn SHALL be 0.
REQ-027 In a busy state with MemAck=1, the arbiter SHALL capture MemReadData into IFInstr (in IF_BUSY) or into DReadData (in D_BUSY for loads only), and then go to RESP.
REQ-028 In RESP, the arbiter SHALL pulse the matching Ready for one cycle and return to IDLE; no grant is made in RESP.
REQ-029 Minimum latency: request sampled in cycle N, MemReq in cycle N+1, MemAck in cycle N+1 gives Ready in cycle N+2, and the next grant is sampled in cycle N+3.
REQ-030 A requester SHALL deassert Req by the cycle after its Ready pulse; a Req still high in IDLE is treated as a new request.
REQ-031 If both requests are pending, the losing fetch SHALL stay pending and be granted at the next IDLE with DReq=0.
REQ-032 MemAck in IDLE or RESP SHALL be ignored.
REQ-033 IFInstr and DReadData SHALL hold their last captured value between transactions; a store SHALL NOT change DReadData.

Reset
REQ-034 On reset, the block SHALL enter IDLE, and MemReq, MemWrite, MemByteEn, IFReady, DReady, Busy and TimeoutErr SHALL be 0; MemAdr, MemWriteData, IFInstr and DReadData SHALL be 0.
REQ-035 Reset during a busy state SHALL abandon the transaction with no Ready pulse; a late MemAck SHALL be ignored per REQ-032.

Configuration
REQ-036 With MEMARB_TIMEOUT_EN defined, an 8-bit-or-wider counter SHALL clear on entry to a busy state and increment each busy cycle without MemAck.
REQ-037 With MEMARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, the arbiter SHALL drop MemReq, capture 32'h0 as read data, go to RESP (Ready pulse), and set TimeoutErr until reset.
REQ-038 Without MEMARB_TIMEOUT_EN, there SHALL be no counter, TimeoutErr SHALL be tied to 0, and a busy state SHALL wait indefinitely for MemAck.

Verification
REQ-039 IFReq=1, IFAdr=0x100, MemAck the next cycle with MemReadData=0x00500093 -> MemReq=1 with MemAdr=0x100 for 1 cycle; IFReady pulses with IFInstr=0x00500093 two cycles after the request.
REQ-040 IFReq and DReq rise in the same cycle, DAdr=0x2000, load, MemReadData=0x12345678 -> data is served first (DReadData=0x12345678); then the fetch is issued with MemAdr equal to IFAdr.
REQ-041 Store, DAdr=0x3004, DWriteData=0x0000AB00, DByteEn=0010, MemAck delayed 3 cycles -> MemWrite=1 and all fields held stable for 3 cycles; DReady pulses once; DReadData unchanged.
REQ-042 Reset asserted in the second cycle of D_BUSY, then MemAck arrives -> MemReq is 0 the cycle after reset; no DReady; state is IDLE.
REQ-043 MEMARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, MemAck never asserted -> MemReq drops after 4 busy cycles; IFReady pulses with IFInstr=0; TimeoutErr=1 until reset. Without the macro, MemReq stays high and TimeoutErr=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter sharing one registered memory port.
// Optional MEMARB_TIMEOUT_EN: abort a busy access after TIMEOUT_CYCLES without MemAck.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFReq,
  input  logic [31:0] IFAdr,
  output logic        IFReady,
  output logic [31:0] IFInstr,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAdr,
  input  logic [31:0] DWriteData,
  input  logic [3:0]  DByteEn,
  output logic        DReady,
  output logic [31:0] DReadData,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAdr,
  output logic [31:0] MemWriteData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemReadData,
  input  logic        MemAck,
  output logic        Busy,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        resp_data_q, resp_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        in_busy;
  logic        timeout_hit;

  assign in_busy = (state_q == IF_BUSY) || (state_q == D_BUSY);

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  // Counter restarts whenever the port is not busy, so it is clear on every busy entry.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if (in_busy && !MemAck) begin
      cnt_d       = cnt_q + 1'b1;
      timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else if (in_busy) begin
      cnt_d = cnt_q;
    end
    terr_d = terr_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign TimeoutErr = terr_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign TimeoutErr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (DReq)       state_d = D_BUSY;
        else if (IFReq) state_d = IF_BUSY;
      end
      IF_BUSY, D_BUSY: begin
        if (MemAck || timeout_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IFReady = (state_q == RESP) && !resp_data_q;
    DReady  = (state_q == RESP) && resp_data_q;
    Busy    = (state_q != IDLE);
  end

  always_comb begin
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = mem_write_q;
    mem_be_d    = mem_be_q;
    if_instr_d  = if_instr_q;
    d_rdata_d   = d_rdata_q;
    resp_data_d = resp_data_q;
    mem_req_d   = (state_d == IF_BUSY) || (state_d == D_BUSY);
    if (state_q == IDLE) begin
      if (DReq) begin
        mem_adr_d   = DAdr;
        mem_wdata_d = DWriteData;
        mem_write_d = DWrite;
        mem_be_d    = DByteEn;
        resp_data_d = 1'b1;
      end else if (IFReq) begin
        mem_adr_d   = IFAdr;
        mem_write_d = 1'b0;
        mem_be_d    = 4'b0000;
        resp_data_d = 1'b0;
      end
    end
    if (!mem_req_d) begin
      mem_write_d = 1'b0;
      mem_be_d    = 4'b0000;
    end
    // A timeout only fires without MemAck, so it returns zero as the read word.
    if (state_q == IF_BUSY && state_d == RESP)
      if_instr_d = MemAck ? MemReadData : 32'h0;
    if (state_q == D_BUSY && state_d == RESP && !mem_write_q)
      d_rdata_d = MemAck ? MemReadData : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_instr_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      resp_data_q <= resp_data_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_instr_q  <= if_instr_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign MemReq       = mem_req_q;
  assign MemWrite     = mem_write_q;
  assign MemAdr       = mem_adr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemByteEn    = mem_be_q;
  assign IFInstr      = if_instr_q;
  assign DReadData    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
`ifdef MEMARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        IFReq, DReq, DWrite, MemAck;
  logic [31:0] IFAdr, DAdr, DWriteData, MemReadData;
  logic [3:0]  DByteEn;
  logic        IFReady, DReady, MemReq, MemWrite, Busy, TimeoutErr;
  logic [31:0] IFInstr, DReadData, MemAdr, MemWriteData;
  logic [3:0]  MemByteEn;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .IFReq(IFReq), .IFAdr(IFAdr), .IFReady(IFReady), .IFInstr(IFInstr),
    .DReq(DReq), .DWrite(DWrite), .DAdr(DAdr), .DWriteData(DWriteData), .DByteEn(DByteEn),
    .DReady(DReady), .DReadData(DReadData),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr), .MemWriteData(MemWriteData),
    .MemByteEn(MemByteEn), .MemReadData(MemReadData), .MemAck(MemAck),
    .Busy(Busy), .TimeoutErr(TimeoutErr)
  );

  int checks = 0;
  int passed = 0;

  // Model: who owns the port (0 none, 1 fetch, 2 data), and whether it is being answered.
  int          owner = 0;
  bit          answering = 0;
  logic [31:0] t_adr = '0, t_wdata = '0;
  logic [3:0]  t_be = '0;
  bit          t_write = 0;
  logic [31:0] m_instr = '0, m_rdata = '0;
  bit          m_terr = 0;
  int          waits = 0;
  bit          chk_en = 0;
  bit          prev_ifr = 0, prev_dr = 0;

  function automatic bit exp_memreq(); return owner != 0 && !answering; endfunction
  function automatic bit exp_ifr();    return answering && owner == 1; endfunction
  function automatic bit exp_dr();     return answering && owner == 2; endfunction

  function automatic void model_step();
    if (reset) begin
      owner = 0; answering = 0; m_instr = '0; m_rdata = '0; m_terr = 0; waits = 0;
    end else if (answering) begin
      answering = 0; owner = 0;
    end else if (owner != 0) begin
      if (MemAck) begin
        if (owner == 1) m_instr = MemReadData;
        else if (!t_write) m_rdata = MemReadData;
        answering = 1;
      end else begin
`ifdef MEMARB_TIMEOUT_EN
        waits++;
        if (waits == TO) begin
          if (owner == 1) m_instr = '0;
          else if (!t_write) m_rdata = '0;
          answering = 1;
          m_terr = 1;
        end
`endif
      end
    end else if (DReq) begin
      owner = 2; t_adr = DAdr; t_wdata = DWriteData; t_be = DByteEn; t_write = DWrite; waits = 0;
    end else if (IFReq) begin
      owner = 1; t_adr = IFAdr; t_be = 4'b0000; t_write = 0; waits = 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    prev_ifr = exp_ifr();
    prev_dr  = exp_dr();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("MemReq", {31'b0, MemReq}, {31'b0, exp_memreq()});
      if (exp_memreq()) begin
        chk("MemAdr", MemAdr, t_adr);
        chk("MemWrite", {31'b0, MemWrite}, {31'b0, t_write});
        chk("MemByteEn", {28'b0, MemByteEn}, {28'b0, t_be});
        if (t_write) chk("MemWriteData", MemWriteData, t_wdata);
      end
      chk("IFReady", {31'b0, IFReady}, {31'b0, exp_ifr()});
      chk("DReady", {31'b0, DReady}, {31'b0, exp_dr()});
      chk("Busy", {31'b0, Busy}, {31'b0, owner != 0});
      chk("IFInstr", IFInstr, m_instr);
      chk("DReadData", DReadData, m_rdata);
      chk("TimeoutErr", {31'b0, TimeoutErr}, {31'b0, m_terr});
    end
  end

  initial begin
    reset = 1; IFReq = 0; IFAdr = '0; DReq = 0; DWrite = 0; DAdr = '0;
    DWriteData = '0; DByteEn = '0; MemAck = 0; MemReadData = '0;
    step();
    chk_en = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("rst_MemReq", {31'b0, MemReq}, 32'd0);
    chk("rst_MemAdr", MemAdr, 32'h0);
    chk("rst_MemByteEn", {28'b0, MemByteEn}, 32'd0);
    chk("rst_IFInstr", IFInstr, 32'h0);
    chk("rst_Busy", {31'b0, Busy}, 32'd0);

    // Single fetch acked on its first busy cycle.
    IFReq = 1; IFAdr = 32'h100;
    step();
    @(negedge clk);
    chk("f1_MemReq", {31'b0, MemReq}, 32'd1);
    chk("f1_MemAdr", MemAdr, 32'h100);
    MemAck = 1; MemReadData = 32'h0050_0093;
    step();
    MemAck = 0;
    @(negedge clk);
    chk("f1_IFReady", {31'b0, IFReady}, 32'd1);
    chk("f1_IFInstr", IFInstr, 32'h0050_0093);
    chk("f1_MemReq_off", {31'b0, MemReq}, 32'd0);
    IFReq = 0;
    step();
    @(negedge clk);
    chk("f1_Busy_off", {31'b0, Busy}, 32'd0);

    // Simultaneous requests: data first, then the held fetch.
    IFReq = 1; IFAdr = 32'h400; DReq = 1; DWrite = 0; DAdr = 32'h2000;
    step();
    @(negedge clk);
    chk("pr_MemAdr_d", MemAdr, 32'h2000);
    MemAck = 1; MemReadData = 32'h1234_5678;
    step();
    MemAck = 0;
    @(negedge clk);
    chk("pr_DReady", {31'b0, DReady}, 32'd1);
    chk("pr_DReadData", DReadData, 32'h1234_5678);
    DReq = 0;
    step();
    step();
    @(negedge clk);
    chk("pr_MemAdr_if", MemAdr, 32'h400);
    MemAck = 1; MemReadData = 32'hCAFE_F00D;
    step();
    MemAck = 0;
    @(negedge clk);
    chk("pr_IFInstr", IFInstr, 32'hCAFE_F00D);
    IFReq = 0;
    step();

    // Store with a delayed ack; fields held, load data untouched.
    DReq = 1; DWrite = 1; DAdr = 32'h3004; DWriteData = 32'h0000_AB00; DByteEn = 4'b0010;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_MemWrite", {31'b0, MemWrite}, 32'd1);
      chk("st_MemAdr", MemAdr, 32'h3004);
      chk("st_MemWriteData", MemWriteData, 32'h0000_AB00);
      chk("st_MemByteEn", {28'b0, MemByteEn}, 32'h2);
      step();
    end
    MemAck = 1; MemReadData = 32'h5555_AAAA;
    step();
    MemAck = 0;
    @(negedge clk);
    chk("st_DReady", {31'b0, DReady}, 32'd1);
    chk("st_DReadData", DReadData, 32'h1234_5678);
    DReq = 0; DWrite = 0;
    step();

    // No ack ever: timeout build aborts, default build keeps waiting.
    IFReq = 1; IFAdr = 32'h600;
    step();
`ifdef MEMARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_MemReq", {31'b0, MemReq}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("to_MemReq_drop", {31'b0, MemReq}, 32'd0);
    chk("to_IFReady", {31'b0, IFReady}, 32'd1);
    chk("to_IFInstr", IFInstr, 32'h0);
    chk("to_TimeoutErr", {31'b0, TimeoutErr}, 32'd1);
    IFReq = 0;
    step();
    step();
    @(negedge clk);
    chk("to_sticky", {31'b0, TimeoutErr}, 32'd1);
`else
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("wait_MemReq", {31'b0, MemReq}, 32'd1);
      chk("wait_TimeoutErr", {31'b0, TimeoutErr}, 32'd0);
      step();
    end
    MemAck = 1; MemReadData = 32'h0BAD_F00D;
    step();
    MemAck = 0;
    @(negedge clk);
    chk("wait_IFReady", {31'b0, IFReady}, 32'd1);
    IFReq = 0;
    step();
`endif

    // Reset in the second data busy cycle, then a late ack.
    DReq = 1; DWrite = 0; DAdr = 32'h5000;
    step();
    step();
    reset = 1;
    step();
    reset = 0; DReq = 0; MemAck = 1; MemReadData = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rb_MemReq", {31'b0, MemReq}, 32'd0);
    chk("rb_Busy", {31'b0, Busy}, 32'd0);
    chk("rb_TimeoutErr", {31'b0, TimeoutErr}, 32'd0);
    step();
    MemAck = 0;
    @(negedge clk);
    chk("rb_DReady", {31'b0, DReady}, 32'd0);
    chk("rb_DReadData", DReadData, 32'h0);
    step();

    for (int c = 0; c < 3000; c++) begin
      if (prev_ifr) IFReq = 0;
      else if (!IFReq && $urandom_range(0, 3) == 0) begin
        IFReq = 1; IFAdr = $urandom;
      end
      if (prev_dr) DReq = 0;
      else if (!DReq && $urandom_range(0, 3) == 0) begin
        DReq = 1; DWrite = 1'($urandom_range(0, 1)); DAdr = $urandom;
        DWriteData = $urandom; DByteEn = 4'($urandom_range(0, 15));
      end
      MemAck = ($urandom_range(0, 2) == 0);
      MemReadData = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
